// File: rtl/ga_pkg.sv
// Shared constants and elaboration helpers for the gate-array clock sequencer.
package ga_pkg;

  localparam int GA_PHASES  = 16;
  localparam int GA_PHASE_W = 4;

  // Modulo-16 distance from the window start, so a window may straddle 15->0.
  function automatic logic inwin(input logic [GA_PHASE_W-1:0] x,
                                 input logic [GA_PHASE_W-1:0] start,
                                 input logic [GA_PHASE_W:0]   len);
    logic [GA_PHASE_W-1:0] off;
    off = x - start;
    return ({1'b0, off} < len);
  endfunction

  function automatic bit ga_params_ok(input int clk_div, input int phi_div,
                                      input int ready_start, input int ready_len);
    bit ok;
    ok = (clk_div >= 2);
    ok = ok && ((phi_div == 2) || (phi_div == 4) || (phi_div == 8) || (phi_div == 16));
    ok = ok && (ready_start >= 0) && (ready_start < GA_PHASES);
    ok = ok && (ready_len >= 1) && (ready_len <= GA_PHASES);
    return ok;
  endfunction

endpackage

// File: rtl/ga_tick_div.sv
// System-clock divider producing the 16 MHz tick enable and its square wave.
module ga_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pause_i,
  output logic cen_16_o,
  output logic clk_16_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q, div_d;
  logic             cen_q, cen_d;

  // The divider keeps running through pause so ticks resume on the grid.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    cen_d = (div_q == '0) & ~pause_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      cen_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cen_q <= cen_d;
    end
  end

  assign cen_16_o = cen_q;
  assign clk_16_o = (div_q >= DIV_HALF);

endmodule

// File: rtl/ga_clkgen.sv
// Gate-array master clock sequencer: 16-phase sequence, PHI/CCLK enables and
// the Z80 READY wait-state generator.
module ga_clkgen
  import ga_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int PHI_DIV     = 4,
  parameter int READY_START = 12,
  parameter int READY_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  input  logic                  pause,
  input  logic                  turbo,
  input  logic                  MREQ_N,
  input  logic                  IORQ_N,
  output logic                  cen_16,
  output logic                  clk_16,
  output logic [GA_PHASE_W-1:0] phase,
  output logic                  PHI_N,
  output logic                  PHI_EN_P,
  output logic                  PHI_EN_N,
  output logic                  CCLK,
  output logic                  CCLK_EN_P,
  output logic                  CCLK_EN_N,
  output logic                  READY
);

  if (!ga_params_ok(CLK_DIV, PHI_DIV, READY_START, READY_LEN)) begin : g_bad_params
    $error("ga_clkgen: illegal parameter set");
  end

  // PHI_DIV is a power of two, so the modulo reduces to a mask.
  localparam logic [GA_PHASE_W-1:0] PHI_MASK  = GA_PHASE_W'(PHI_DIV - 1);
  localparam logic [GA_PHASE_W-1:0] PHI_HALF  = GA_PHASE_W'(PHI_DIV / 2);
  localparam logic [GA_PHASE_W-1:0] PHI_RISE  = GA_PHASE_W'(PHI_DIV / 2 - 1);
  localparam logic [GA_PHASE_W-1:0] WIN_START = GA_PHASE_W'(READY_START);
  localparam logic [GA_PHASE_W:0]   WIN_LEN   = (GA_PHASE_W+1)'(READY_LEN);

  logic                  tick;
  logic [GA_PHASE_W-1:0] phase_q, phase_d;
  logic                  ready_q, ready_d;
  logic                  req;
  logic [GA_PHASE_W-1:0] phi_p;

  ga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk_i    (clk),
    .rst_ni   (RESET_N),
    .pause_i  (pause),
    .cen_16_o (tick),
    .clk_16_o (clk_16)
  );

  assign req = ~MREQ_N | ~IORQ_N;

  // READY is judged against the phase being entered, so a wait decision
  // lines up with the slot the CPU will actually see.
  always_comb begin
    phase_d = phase_q;
    ready_d = ready_q;
    if (tick) begin
      phase_d = phase_q + 1'b1;
      ready_d = ~req | inwin(phase_d, WIN_START, WIN_LEN);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q <= '0;
      ready_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      ready_q <= ready_d;
    end
  end

  assign phi_p     = phase_q & PHI_MASK;
  assign cen_16    = tick;
  assign phase     = phase_q;
  assign PHI_N     = (phi_p < PHI_HALF);
  assign PHI_EN_P  = tick & (phi_p == PHI_RISE);
  assign PHI_EN_N  = tick & (phi_p == PHI_MASK);
  assign CCLK      = ~phase_q[GA_PHASE_W-1];
  assign CCLK_EN_N = tick & (phase_q == 4'd7);
  assign CCLK_EN_P = tick & (phase_q == 4'd15);
  assign READY     = ready_q | turbo;

endmodule

// File: tb/tb_ga_clkgen.sv
// Directed bench for ga_clkgen: default instance plus PHI_DIV=2 / wrapped
// READY window and full-length READY window instances.
`timescale 1ns/1ps
module tb_ga_clkgen;

  logic clk = 1'b0;
  logic RESET_N, pause, turbo, MREQ_N, IORQ_N;

  logic       cen_16, clk_16, PHI_N, PHI_EN_P, PHI_EN_N, CCLK, CCLK_EN_P, CCLK_EN_N, READY;
  logic [3:0] phase;
  logic       a_cen_16, a_clk_16, a_PHI_N, a_PHI_EN_P, a_PHI_EN_N, a_CCLK, a_CCLK_EN_P, a_CCLK_EN_N, a_READY;
  logic [3:0] a_phase;
  logic       f_cen_16, f_clk_16, f_PHI_N, f_PHI_EN_P, f_PHI_EN_N, f_CCLK, f_CCLK_EN_P, f_CCLK_EN_N, f_READY;
  logic [3:0] f_phase;

  int checks = 0;
  int errors = 0;

  int m_div;
  int m_ph;
  bit m_cen;
  bit m_rdy_d;
  bit m_rdy_a;

  always #5 clk = ~clk;

  ga_clkgen u_dut (
    .clk(clk), .RESET_N(RESET_N), .pause(pause), .turbo(turbo), .MREQ_N(MREQ_N), .IORQ_N(IORQ_N),
    .cen_16(cen_16), .clk_16(clk_16), .phase(phase), .PHI_N(PHI_N), .PHI_EN_P(PHI_EN_P),
    .PHI_EN_N(PHI_EN_N), .CCLK(CCLK), .CCLK_EN_P(CCLK_EN_P), .CCLK_EN_N(CCLK_EN_N), .READY(READY)
  );

  ga_clkgen #(.CLK_DIV(4), .PHI_DIV(2), .READY_START(14), .READY_LEN(4)) u_alt (
    .clk(clk), .RESET_N(RESET_N), .pause(pause), .turbo(turbo), .MREQ_N(MREQ_N), .IORQ_N(IORQ_N),
    .cen_16(a_cen_16), .clk_16(a_clk_16), .phase(a_phase), .PHI_N(a_PHI_N), .PHI_EN_P(a_PHI_EN_P),
    .PHI_EN_N(a_PHI_EN_N), .CCLK(a_CCLK), .CCLK_EN_P(a_CCLK_EN_P), .CCLK_EN_N(a_CCLK_EN_N), .READY(a_READY)
  );

  ga_clkgen #(.READY_LEN(16)) u_full (
    .clk(clk), .RESET_N(RESET_N), .pause(pause), .turbo(turbo), .MREQ_N(MREQ_N), .IORQ_N(IORQ_N),
    .cen_16(f_cen_16), .clk_16(f_clk_16), .phase(f_phase), .PHI_N(f_PHI_N), .PHI_EN_P(f_PHI_EN_P),
    .PHI_EN_N(f_PHI_EN_N), .CCLK(f_CCLK), .CCLK_EN_P(f_CCLK_EN_P), .CCLK_EN_N(f_CCLK_EN_N), .READY(f_READY)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div   = 0;
    m_cen   = 1'b0;
    m_ph    = 0;
    m_rdy_d = 1'b1;
    m_rdy_a = 1'b1;
  endtask

  // Default window is phases 12..15; the alternate window wraps: 14,15,0,1.
  function automatic bit win_d(input int ph);
    return (ph >= 12);
  endfunction

  function automatic bit win_a(input int ph);
    return (ph >= 14) || (ph <= 1);
  endfunction

  task automatic check_all();
    int p4;
    int p2;
    p4 = m_ph % 4;
    p2 = m_ph % 2;
    chk("cen_16",     cen_16,    m_cen);
    chk("clk_16",     clk_16,    m_div >= 2);
    chk("phase",      phase,     m_ph);
    chk("phi_n",      PHI_N,     p4 < 2);
    chk("phi_en_p",   PHI_EN_P,  m_cen && p4 == 1);
    chk("phi_en_n",   PHI_EN_N,  m_cen && p4 == 3);
    chk("cclk",       CCLK,      m_ph < 8);
    chk("cclk_en_n",  CCLK_EN_N, m_cen && m_ph == 7);
    chk("cclk_en_p",  CCLK_EN_P, m_cen && m_ph == 15);
    chk("ready",      READY,     m_rdy_d | turbo);
    chk("a_phase",    a_phase,   m_ph);
    chk("a_phi_n",    a_PHI_N,   p2 == 0);
    chk("a_phi_en_p", a_PHI_EN_P, m_cen && p2 == 0);
    chk("a_phi_en_n", a_PHI_EN_N, m_cen && p2 == 1);
    chk("a_ready",    a_READY,   m_rdy_a | turbo);
    chk("f_ready",    f_READY,   1'b1);
  endtask

  // One clk cycle: inputs are taken as they stand before the rising edge,
  // outputs are compared on the following falling edge.
  task automatic step();
    bit req;
    bit ncen;
    req  = !MREQ_N || !IORQ_N;
    ncen = (m_div == 0) && !pause;
    @(posedge clk);
    if (!RESET_N) begin
      model_reset();
    end else begin
      if (m_cen) begin
        m_ph    = (m_ph + 1) % 16;
        m_rdy_d = !req || win_d(m_ph);
        m_rdy_a = !req || win_a(m_ph);
      end
      m_div = (m_div + 1) % 4;
      m_cen = ncen;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit found;
    RESET_N = 1'b1;
    pause   = 1'b0;
    turbo   = 1'b0;
    MREQ_N  = 1'b1;
    IORQ_N  = 1'b1;
    model_reset();

    // Reset asserted before any clock edge must take effect on its own.
    #1 RESET_N = 1'b0;
    #1 check_all();
    repeat (4) step();

    // Free run: two full 16-phase sequences.
    RESET_N = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (k == 1 || k == 5 || k == 9) chk("cen_edge", cen_16, 1'b1);
      if (k == 2 || k == 3 || k == 4) chk("cen_gap", cen_16, 1'b0);
    end

    // MREQ falls at phase 2: wait from phase 3 through 11.
    for (int i = 0; i < 64 && m_ph != 2; i++) step();
    chk("mreq_start_phase", phase, 4'd2);
    MREQ_N = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (m_ph == 3 && m_cen == 1'b0 && m_div == 2) chk("ready_low_ph3", READY, 1'b0);
      if (m_ph == 12 && m_div == 2) chk("ready_high_ph12", READY, 1'b1);
    end
    MREQ_N = 1'b1;
    repeat (12) step();
    IORQ_N = 1'b0;
    repeat (40) step();
    IORQ_N = 1'b1;
    repeat (8) step();

    // Turbo overrides READY combinationally.
    turbo  = 1'b1;
    #1 chk("turbo_rise", READY, 1'b1);
    MREQ_N = 1'b0;
    repeat (40) step();
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (m_ph == 5 && !m_rdy_d) found = 1'b1;
    end
    chk("turbo_wait_phase", phase, 4'd5);
    turbo = 1'b0;
    #1 chk("turbo_drop", READY, m_rdy_d);
    MREQ_N = 1'b1;
    repeat (20) step();

    // Pause at phase 6 for 20 clk.
    for (int i = 0; i < 80 && m_ph != 6; i++) step();
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pause_phase", phase, 4'd6);
      chk("pause_no_en", {cen_16, PHI_EN_P, PHI_EN_N, CCLK_EN_P, CCLK_EN_N}, 8'h00);
    end
    pause = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (cen_16) found = 1'b1;
    end
    chk("resume_tick", cen_16, 1'b1);
    chk("resume_phase", phase, 4'd6);
    repeat (12) step();

    // Reset pulsed during pause clears state without a clock edge.
    pause = 1'b1;
    repeat (3) step();
    RESET_N = 1'b0;
    #1 model_reset();
    chk("rst_async_phase", phase, 4'd0);
    chk("rst_async_ready", READY, 1'b1);
    check_all();
    repeat (2) step();
    pause   = 1'b0;
    RESET_N = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
